cpu_run_ctrl: RTL and testbench



---
 rtl/cpu_run_ctrl.sv | 156 +++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run sequencer for the single-cycle CPU core.
//
// The host raises req. The block holds the core in reset for INIT_CYC
// cycles, then lets the program run. It stops when the PC reaches
// HALT_ADDR or when the MAX_CYC cycle budget is used up. It then
// freezes the PC for DRAIN_CYC cycles and reports done until the host
// drops req.
//
// Ports:
//   clk       system clock
//   reset     synchronous, active-high reset
//   req       start request (level, four-phase handshake with done)
//   abort     synchronous abort, returns to IDLE
//   prog_ctr  current PC from the core
//   core_rst  reset to the core (PC, flags, sc register)
//   core_en   PC advance / RegWrite / MemWrite enable to the core
//   busy      high in INIT, RUN and DRAIN
//   done      high in DONE
//   timeout   last run ended on the cycle budget rather than on halt
//   cycles    RUN cycles counted in the last or current run
//
// state | meaning
// IDLE  | core held in reset, waiting for req
// INIT  | core held in reset for INIT_CYC cycles
// RUN   | core running, cycles counting, halt/budget watched
// DRAIN | PC frozen for DRAIN_CYC cycles so final writes settle
// DONE  | result reported, core state held until req drops

module cpu_run_ctrl #(
   parameter int D         = 12,
   parameter int HALT_ADDR = 128,
   parameter int INIT_CYC  = 2,
   parameter int DRAIN_CYC = 1,
   parameter int CW        = 16,
   parameter int MAX_CYC   = 65535
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req,
   input  logic          abort,
   input  logic [D-1:0]  prog_ctr,
   output logic          core_rst,
   output logic          core_en,
   output logic          busy,
   output logic          done,
   output logic          timeout,
   output logic [CW-1:0] cycles
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_t;

   localparam logic [3:0]    INIT_TC   = 4'(INIT_CYC - 1);
   localparam logic [3:0]    DRAIN_TC  = (DRAIN_CYC > 0) ? 4'(DRAIN_CYC - 1) : 4'd0;
   localparam logic [CW-1:0] BUDGET_TC = CW'(MAX_CYC - 1);
   localparam logic [D-1:0]  HALT_PC   = D'(HALT_ADDR);

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [CW-1:0] cycles_q, cycles_d;
   logic          timeout_q, timeout_d;
   logic [CW-1:0] cycles_inc;

   assign cycles_inc = (cycles_q == '1) ? cycles_q : cycles_q + CW'(1);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cycles_d  = cycles_q;
      timeout_d = timeout_q;

      if (abort) begin
         state_d   = ST_IDLE;
         cnt_d     = '0;
         timeout_d = 1'b0;
         // the core was enabled during the abort cycle, so it still counts
         if (state_q == ST_RUN) begin
            cycles_d = cycles_inc;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req) begin
                  state_d   = ST_INIT;
                  cnt_d     = '0;
                  cycles_d  = '0;
                  timeout_d = 1'b0;
               end
            end
            ST_INIT: begin
               if (cnt_q == INIT_TC) begin
                  state_d = ST_RUN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
            ST_RUN: begin
               cycles_d = cycles_inc;
               // halt is tested first so it wins over a budget expiry
               if (prog_ctr == HALT_PC) begin
                  state_d = (DRAIN_CYC == 0) ? ST_DONE : ST_DRAIN;
                  cnt_d   = '0;
               end else if (cycles_q == BUDGET_TC) begin
                  state_d   = ST_DONE;
                  timeout_d = 1'b1;
               end
            end
            ST_DRAIN: begin
               if (cnt_q == DRAIN_TC) begin
                  state_d = ST_DONE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
            ST_DONE: begin
               if (!req) begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         cycles_q  <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         cycles_q  <= cycles_d;
         timeout_q <= timeout_d;
      end
   end

   assign core_rst = (state_q == ST_IDLE) || (state_q == ST_INIT);
   assign core_en  = (state_q == ST_RUN);
   assign busy     = (state_q == ST_INIT) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign done     = (state_q == ST_DONE);
   assign timeout  = timeout_q;
   assign cycles   = cycles_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl. Four instances cover the default build, two
// cycle budgets and a no-drain / short-init build. A small PC model
// stands in for the core. Stimulus pushes expected end-of-run records,
// done-length values and output snapshots into queues; the monitor pops
// and compares them when the selected instance presents the matching event.

module tb_cpu_run_ctrl;

   typedef struct packed {
      logic        done;
      logic        timeout;
      logic        core_rst;
      logic [15:0] cycles;
      logic [7:0]  n_init;
      logic [7:0]  n_run;
      logic [7:0]  n_drain;
   } ev_t;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic        rst_p = 1'b0;
   logic [3:0]  req_r   = '0;
   logic [3:0]  abort_r = '0;
   logic [11:0] pc_r     [4];
   logic [11:0] pc_start [4];
   logic [3:0]  rst_w, en_w, busy_w, done_w, to_w;
   logic [15:0] cyc_w [4];
   int          sel = 0;

   int n_pass  = 0;
   int n_total = 0;

   ev_t         ev_q[$];
   int          done_q[$];
   logic [20:0] snap_q[$];

   always #5 clk = ~clk;

   cpu_run_ctrl u0 (
      .clk(clk), .reset(reset), .req(req_r[0]), .abort(abort_r[0]), .prog_ctr(pc_r[0]),
      .core_rst(rst_w[0]), .core_en(en_w[0]), .busy(busy_w[0]), .done(done_w[0]),
      .timeout(to_w[0]), .cycles(cyc_w[0]));

   cpu_run_ctrl #(.MAX_CYC(20)) u1 (
      .clk(clk), .reset(reset), .req(req_r[1]), .abort(abort_r[1]), .prog_ctr(pc_r[1]),
      .core_rst(rst_w[1]), .core_en(en_w[1]), .busy(busy_w[1]), .done(done_w[1]),
      .timeout(to_w[1]), .cycles(cyc_w[1]));

   cpu_run_ctrl #(.MAX_CYC(10)) u2 (
      .clk(clk), .reset(reset), .req(req_r[2]), .abort(abort_r[2]), .prog_ctr(pc_r[2]),
      .core_rst(rst_w[2]), .core_en(en_w[2]), .busy(busy_w[2]), .done(done_w[2]),
      .timeout(to_w[2]), .cycles(cyc_w[2]));

   cpu_run_ctrl #(.INIT_CYC(1), .DRAIN_CYC(0)) u3 (
      .clk(clk), .reset(reset), .req(req_r[3]), .abort(abort_r[3]), .prog_ctr(pc_r[3]),
      .core_rst(rst_w[3]), .core_en(en_w[3]), .busy(busy_w[3]), .done(done_w[3]),
      .timeout(to_w[3]), .cycles(cyc_w[3]));

   // core model: PC loads its start value under reset, advances when enabled
   always @(posedge clk) begin
      rst_p <= reset;
      for (int i = 0; i < 4; i++) begin
         if (rst_w[i]) pc_r[i] <= pc_start[i];
         else if (en_w[i]) pc_r[i] <= pc_r[i] + 12'd1;
      end
   end

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endfunction

   function automatic logic [20:0] mk_snap(logic r, logic e, logic b, logic d, logic t,
                                           logic [15:0] c);
      return {r, e, b, d, t, c};
   endfunction

   function automatic ev_t mk_ev(logic d, logic t, logic r, int c, int ni, int nr, int nd);
      ev_t e;
      e.done = d; e.timeout = t; e.core_rst = r; e.cycles = 16'(c);
      e.n_init = 8'(ni); e.n_run = 8'(nr); e.n_drain = 8'(nd);
      return e;
   endfunction

   // monitor
   int          n_init = 0, n_run = 0, n_drain = 0, n_done = 0;
   logic        p_busy = 1'b0, p_done = 1'b0;
   logic [15:0] cyc_hold = '0;
   logic        to_hold = 1'b0;
   logic        m_rst, m_en, m_busy, m_done, m_to;
   logic [15:0] m_cyc;
   ev_t         m_ev;
   int          m_nd;
   logic [20:0] m_snap;

   always @(negedge clk) begin
      m_rst = rst_w[sel]; m_en = en_w[sel]; m_busy = busy_w[sel];
      m_done = done_w[sel]; m_to = to_w[sel]; m_cyc = cyc_w[sel];

      if (rst_p) begin
         for (int i = 0; i < 4; i++)
            chk($sformatf("reset_state[%0d]", i),
                64'(mk_snap(rst_w[i], en_w[i], busy_w[i], done_w[i], to_w[i], cyc_w[i])),
                64'(mk_snap(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0)));
      end

      if (m_busy && !p_busy) begin
         n_init = 0; n_run = 0; n_drain = 0;
      end
      if (m_busy) begin
         if (m_rst) n_init++;
         else if (m_en) n_run++;
         else n_drain++;
      end

      if (p_busy && !m_busy) begin
         if (ev_q.size() == 0) begin
            chk("unexpected_run_end", 64'(1), 64'(0));
         end else begin
            m_ev = ev_q.pop_front();
            chk("end_done",     64'(m_done),  64'(m_ev.done));
            chk("end_cycles",   64'(m_cyc),   64'(m_ev.cycles));
            chk("end_timeout",  64'(m_to),    64'(m_ev.timeout));
            chk("end_core_rst", 64'(m_rst),   64'(m_ev.core_rst));
            chk("end_core_en",  64'(m_en),    64'(0));
            chk("init_cycles",  64'(n_init),  64'(m_ev.n_init));
            chk("run_cycles",   64'(n_run),   64'(m_ev.n_run));
            chk("drain_cycles", 64'(n_drain), 64'(m_ev.n_drain));
         end
      end

      if (m_done) begin
         if (!p_done) begin
            n_done = 0; cyc_hold = m_cyc; to_hold = m_to;
         end else begin
            chk("done_cycles_stable",  64'(m_cyc), 64'(cyc_hold));
            chk("done_timeout_stable", 64'(m_to),  64'(to_hold));
         end
         n_done++;
      end

      if (p_done && !m_done) begin
         if (done_q.size() == 0) begin
            chk("unexpected_done_fall", 64'(1), 64'(0));
         end else begin
            m_nd = done_q.pop_front();
            chk("done_length",        64'(n_done), 64'(m_nd));
            chk("after_done_core_rst", 64'(m_rst), 64'(1));
         end
      end

      if (snap_q.size() != 0) begin
         m_snap = snap_q.pop_front();
         chk("snapshot", 64'(mk_snap(m_rst, m_en, m_busy, m_done, m_to, m_cyc)), 64'(m_snap));
      end

      p_busy = m_busy;
      p_done = m_done;
   end

   // stimulus
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   function automatic void expire(string name);
      n_total++;
      $display("FAIL %s: bound of 200 cycles expired, required event not seen", name);
   endfunction

   task automatic wait_en();
      int k = 0;
      while (!en_w[sel] && k < 200) begin step(); k++; end
      if (!en_w[sel]) expire("wait_run");
   endtask

   task automatic wait_done();
      int k = 0;
      while (!done_w[sel] && k < 200) begin step(); k++; end
      if (!done_w[sel]) expire("wait_done");
   endtask

   task automatic wait_idle();
      int k = 0;
      while ((busy_w[sel] || done_w[sel]) && k < 200) begin step(); k++; end
      if (busy_w[sel] || done_w[sel]) expire("wait_idle");
   endtask

   task automatic start_run(int s, int start, ev_t e, int nd);
      sel = s;
      pc_start[s] = 12'(start);
      ev_q.push_back(e);
      if (nd > 0) done_q.push_back(nd);
      step();
      req_r[s] = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 4; i++) pc_start[i] = '0;
      reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      step();

      // basic run: halt on RUN cycle 10, one drain cycle
      start_run(0, 119, mk_ev(1, 0, 0, 10, 2, 10, 1), 1);
      wait_done(); req_r[0] = 1'b0; wait_idle();

      // timeout with PC wrapping past 4095; req dropped mid-run is ignored
      start_run(1, 4090, mk_ev(1, 1, 0, 20, 2, 20, 0), 1);
      wait_en(); req_r[1] = 1'b0; wait_done(); wait_idle();
      snap_q.push_back(mk_snap(1, 0, 0, 0, 1, 16'd20));
      step();
      abort_r[1] = 1'b1;
      snap_q.push_back(mk_snap(1, 0, 0, 0, 0, 16'd20));
      step();
      abort_r[1] = 1'b0;

      // PC 2176 shares its low 11 bits with HALT_ADDR: must not halt
      start_run(1, 2170, mk_ev(1, 1, 0, 20, 2, 20, 0), 1);
      wait_done(); req_r[1] = 1'b0; wait_idle();

      // halt on the budget cycle: halt wins
      start_run(2, 119, mk_ev(1, 0, 0, 10, 2, 10, 1), 1);
      wait_done(); req_r[2] = 1'b0; wait_idle();

      // handshake: req held through DONE, then a fresh run
      start_run(0, 124, mk_ev(1, 0, 0, 5, 2, 5, 1), 5);
      wait_done(); repeat (4) step(); req_r[0] = 1'b0; wait_idle();
      step();
      start_run(0, 126, mk_ev(1, 0, 0, 3, 2, 3, 1), 1);
      wait_done(); req_r[0] = 1'b0; wait_idle();

      // abort on RUN cycle 4
      start_run(0, 0, mk_ev(0, 0, 1, 4, 2, 4, 0), 0);
      wait_en(); repeat (3) step();
      abort_r[0] = 1'b1;
      step();
      abort_r[0] = 1'b0; req_r[0] = 1'b0;
      step();
      // abort in IDLE with simultaneous req: stays idle, cycles held
      req_r[0] = 1'b1; abort_r[0] = 1'b1;
      snap_q.push_back(mk_snap(1, 0, 0, 0, 0, 16'd4));
      step();
      req_r[0] = 1'b0; abort_r[0] = 1'b0;
      step();

      // reset on RUN cycle 4
      start_run(0, 0, mk_ev(0, 0, 1, 0, 2, 4, 0), 0);
      wait_en(); repeat (3) step();
      reset = 1'b1; req_r[0] = 1'b0;
      step();
      reset = 1'b0;
      step();

      // no drain, one init cycle
      start_run(3, 126, mk_ev(1, 0, 0, 3, 1, 3, 0), 1);
      wait_done(); req_r[3] = 1'b0; wait_idle();

      repeat (3) step();
      chk("pending_run_ends",  64'(ev_q.size()),   64'(0));
      chk("pending_done_falls", 64'(done_q.size()), 64'(0));
      chk("pending_snapshots", 64'(snap_q.size()), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required normal end");
      $fatal(1, "watchdog");
   end

endmodule
